sample_packer: RTL

SAMPLE_PACKER -- requirements
Module: sample_packer

---
 rtl/sample_packer.sv | 114 +++++++++++
 1 files changed

// File: rtl/sample_packer.sv
// I/Q sample packer: decimates captured samples, packs {Q,I} into one word and
// feeds a downstream FIFO through a 2-entry skid buffer with overflow counting.
module sample_packer #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      decim,
  input  logic                  in_valid,
  input  logic [SAMPLE_W-1:0]   in_i,
  input  logic [SAMPLE_W-1:0]   in_q,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [2*SAMPLE_W-1:0] fifo_wr_data,
  input  logic                  clear_ovf,
  output logic [CNT_W-1:0]      overflow_cnt,
  output logic [1:0]            buf_level
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  buf_state_t            state_reg;
  logic [CNT_W-1:0]      phase_reg;
  logic [2*SAMPLE_W-1:0] head_reg;
  logic [2*SAMPLE_W-1:0] tail_reg;
  logic [CNT_W-1:0]      ovf_reg;

  logic                  seen;
  logic                  keep;
  logic                  pop;
  logic                  drop;
  logic [2*SAMPLE_W-1:0] new_word;

  assign seen     = in_valid && enable;
  assign keep     = seen && (phase_reg == '0);
  assign pop      = (state_reg != BUF_EMPTY) && !fifo_full;
  assign drop     = keep && (state_reg == BUF_TWO) && !pop;
  assign new_word = {in_q, in_i};

  assign fifo_wr_en   = pop;
  assign fifo_wr_data = (state_reg == BUF_EMPTY) ? '0 : head_reg;
  assign buf_level    = state_reg;
  assign overflow_cnt = ovf_reg;

  // The >= compare wraps the phase even when decim drops below it mid-run.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      phase_reg <= '0;
    end else if (!enable) begin
      phase_reg <= '0;
    end else if (seen) begin
      phase_reg <= (phase_reg >= decim) ? '0 : phase_reg + CNT_W'(1);
    end
  end

  // head_reg is always the oldest entry; tail_reg is only meaningful in BUF_TWO.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= BUF_EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case (state_reg)
        BUF_EMPTY: begin
          if (keep) begin
            head_reg  <= new_word;
            state_reg <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (keep && pop) begin
            head_reg <= new_word;
          end else if (keep) begin
            tail_reg  <= new_word;
            state_reg <= BUF_TWO;
          end else if (pop) begin
            state_reg <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (pop) begin
            head_reg <= tail_reg;
            if (keep) begin
              tail_reg <= new_word;
            end else begin
              state_reg <= BUF_ONE;
            end
          end
        end
        default: begin
          state_reg <= BUF_EMPTY;
        end
      endcase
    end
  end

  // Clear wins over a coincident drop; the count saturates at all-ones.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ovf_reg <= '0;
    end else if (clear_ovf) begin
      ovf_reg <= '0;
    end else if (drop && (ovf_reg != '1)) begin
      ovf_reg <= ovf_reg + CNT_W'(1);
    end
  end

endmodule
